interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Sequences the CPU register file and memory bus through the 6502 reset/NMI/BRK/IRQ entry sequences.
- Pushes PCH, PCL and P to the stack page, sets I, fetches the 16-bit vector and loads PC.
- Sits beside the instruction-decode FSM. The core hands control over at an instruction boundary and takes it back on `done`.

Parameters:
- NMI_VEC, 16'hFFFA, NMI vector low-byte address
- RST_VEC, 16'hFFFC, reset vector low-byte address
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address
- STACK_PAGE, 8'h01, high byte of stack addresses
- FETCH_RESET_VECTOR, 1, 1 = run the reset vector fetch after reset; 0 = keep the hardwired PC, no sequence

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- nmi_n  in  1  NMI request, falling-edge sensitive, synchronous to clk
- irq_n  in  1  IRQ request, level, active-low
- brk_req  in  1  core decoded BRK; valid only with at_boundary
- at_boundary  in  1  core is at an opcode-fetch boundary and may yield
- I_flag  in  1  interrupt-disable flag from the register file
- PC_in  in  16  current PC (already advanced past the BRK padding byte)
- SP_in  in  8  current SP
- P_in  in  8  current status register
- mem_rdata  in  8  read data, valid when mem_ready=1
- mem_ready  in  1  memory access complete this cycle
- mem_addr  out  16  bus address
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe, held until mem_ready
- mem_re  out  1  read strobe, held until mem_ready
- dec_SP  out  1  one-cycle SP decrement pulse
- set_I  out  1  one-cycle set-I pulse
- pc_load  out  1  one-cycle full-PC load strobe
- pc_value  out  16  vector value for pc_load
- busy  out  1  sequencer owns bus and register controls
- done  out  1  one-cycle completion pulse
- int_src  out  2  active source: 0=RST, 1=NMI, 2=BRK, 3=IRQ

Behaviour:
- **States:** IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD_PC.
- **Reset values:**
  - All strobes, busy and done are 0.
  - mem_addr=0, mem_wdata=0, pc_value=0, int_src=0.
  - NMI pending flag cleared; nmi_n edge-detect history set to 1.
- **Reset entry:**
  - If FETCH_RESET_VECTOR=1: the first cycle after reset release enters VEC_LO with int_src=0. Pushes are skipped.
  - If FETCH_RESET_VECTOR=0: the FSM stays in IDLE.
- **NMI edge detect:** nmi_n 1→0 between consecutive cycles sets nmi_pending.
  - Pending is cleared only when an NMI sequence is accepted.
  - An edge arriving during any sequence stays pending.
- **Acceptance:** evaluated in IDLE only, when at_boundary=1. Priority is NMI > BRK > IRQ.
  - IRQ is accepted only if irq_n=0 and I_flag=0.
  - Accepting latches int_src and captures PC_in and P_in into internal registers, then goes to PUSH_PCH.
- **PUSH_PCH / PUSH_PCL / PUSH_P:**
  - mem_addr={STACK_PAGE, SP_in}, mem_we=1.
  - Write data is PC[15:8], PC[7:0], then the pushed P.
  - Pushed P = captured P with bit5=1; bit4=1 for BRK, bit4=0 otherwise.
  - On the mem_ready cycle: dec_SP pulses and the state advances.
  - In PUSH_P, set_I also pulses on the mem_ready cycle.
- **VEC_LO / VEC_HI:**
  - mem_re=1; mem_addr = vector base, then base+1.
  - Vector base: RST_VEC, NMI_VEC, or IRQ_VEC for BRK and IRQ.
  - On the mem_ready cycle, mem_rdata is captured into pc_value[7:0] or [15:8].
  - VEC_LO for reset also pulses set_I.
- **LOAD_PC:** pc_load=1 and done=1 for one cycle, then IDLE.
- **Latency:** with mem_ready tied high:
  - Accept edge N; PUSH_PCH at N+1; LOAD_PC at N+6; IDLE at N+7.
  - Reset sequence: LOAD_PC on the third cycle after release.
- **Wait states:** any number are tolerated; outputs hold stable while mem_ready=0.
- **busy:** 1 in every non-IDLE state.
- **Stack wrap:** SP wraps 00→FF inside the register file. Addresses always stay in STACK_PAGE; no overflow detection.
- **Mid-operation reset:** asserting reset_n low mid-sequence aborts immediately and all outputs return to reset values. Partial stack writes are not undone.
- **Level IRQ:** irq_n released before acceptance means no sequence. irq_n deasserted after acceptance has no effect.

Decomposition:
- Shared package `cpu6502_pkg` holds:
  - the state enum;
  - the int_src encodings;
  - P bit indices (C=0, Z=1, I=2, D=3, B=4, U=5, V=6, N=7);
  - default vector constants.
- One natural sub-module, `nmi_edge_latch`: edge detect plus pending flag with accept-clear.

Test Plan:
- Reset release, FETCH_RESET_VECTOR=1, memory FFFC=00/FFFD=FF, mem_ready=1 → reads FFFC then FFFD; pc_load with pc_value=FF00; set_I pulse; no mem_we; done one cycle.
- IRQ: irq_n=0, I_flag=0, at_boundary, PC_in=1234, SP_in=FF, P_in=20 → writes 01FF=12, 01FE=34, 01FD=20 with three dec_SP pulses and set_I; then reads FFFE/FFFF; pc_load at N+6.
- irq_n=0 with I_flag=1 → no sequence; busy stays 0.
- BRK with P_in=A1 → pushed P=B1, vector from FFFE, int_src=2.
- NMI edge while irq_n=0 → NMI wins, vector FFFA. A second NMI edge during the sequence → second sequence starts at the next at_boundary.
- mem_ready low 3 cycles during PUSH_PCL → mem_addr and mem_wdata stable, one dec_SP only. Reset asserted in VEC_HI → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/cpu6502_pkg.sv
// Shared types for the 6502 core: sequencer states,
// interrupt source codes, status bit positions and vectors.
package cpu6502_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUSH_PCH,
      ST_PUSH_PCL,
      ST_PUSH_P,
      ST_VEC_LO,
      ST_VEC_HI,
      ST_LOAD_PC
   } seq_state_e;

   typedef enum logic [1:0] {
      SRC_RST = 2'd0,
      SRC_NMI = 2'd1,
      SRC_BRK = 2'd2,
      SRC_IRQ = 2'd3
   } int_src_e;

   typedef enum int unsigned {
      P_C = 0,
      P_Z = 1,
      P_I = 2,
      P_D = 3,
      P_B = 4,
      P_U = 5,
      P_V = 6,
      P_N = 7
   } pbit_e;

   localparam logic [15:0] NMI_VEC_DEF    = 16'hFFFA;
   localparam logic [15:0] RST_VEC_DEF    = 16'hFFFC;
   localparam logic [15:0] IRQ_VEC_DEF    = 16'hFFFE;
   localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;

   // Status byte as it lands on the stack: U always set,
   // B tells the handler whether it came from BRK.
   function automatic logic [7:0] push_status(
      input logic [7:0] p,
      input logic       brk
   );
      logic [7:0] r;
      r       = p;
      r[P_U]  = 1'b1;
      r[P_B]  = brk;
      return r;
   endfunction

endpackage

// File: rtl/nmi_edge_latch.sv
// NMI falling-edge detector with a sticky pending flag
// that only the sequencer's acceptance clears.
module nmi_edge_latch (
   input  logic clk,
   input  logic reset_n,
   input  logic nmi_n_i,
   input  logic clr_i,
   output logic pending_o
);

   logic nmi_q;
   logic pend_q;
   logic pend_d;
   logic fall;

   assign fall = nmi_q & ~nmi_n_i;

   // A new edge wins over a same-cycle clear so it is never lost
   always_comb begin
      pend_d = fall | (pend_q & ~clr_i);
   end

   // History and pending registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nmi_q  <= 1'b1;
         pend_q <= 1'b0;
      end else begin
         nmi_q  <= nmi_n_i;
         pend_q <= pend_d;
      end
   end

   assign pending_o = pend_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/BRK/IRQ entry sequencer: pushes PC and P,
// sets I, fetches the vector and hands a new PC to the core.
module interrupt_sequencer
   import cpu6502_pkg::*;
#(
   parameter logic [15:0] NMI_VEC            = NMI_VEC_DEF,
   parameter logic [15:0] RST_VEC            = RST_VEC_DEF,
   parameter logic [15:0] IRQ_VEC            = IRQ_VEC_DEF,
   parameter logic [7:0]  STACK_PAGE         = STACK_PAGE_DEF,
   parameter bit          FETCH_RESET_VECTOR = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        nmi_n,
   input  logic        irq_n,
   input  logic        brk_req,
   input  logic        at_boundary,
   input  logic        I_flag,
   input  logic [15:0] PC_in,
   input  logic [7:0]  SP_in,
   input  logic [7:0]  P_in,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   output logic        dec_SP,
   output logic        set_I,
   output logic        pc_load,
   output logic [15:0] pc_value,
   output logic        busy,
   output logic        done,
   output logic [1:0]  int_src
);

   seq_state_e  state_q, state_d;
   int_src_e    src_q, src_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  p_q, p_d;
   logic [15:0] vec_q, vec_d;
   logic        rst_pend_q, rst_pend_d;

   logic        nmi_pend;
   logic        nmi_clr;
   logic        irq_ok;
   logic [15:0] vec_base;
   logic [15:0] stack_addr;

   nmi_edge_latch u_nmi (
      .clk       (clk),
      .reset_n   (reset_n),
      .nmi_n_i   (nmi_n),
      .clr_i     (nmi_clr),
      .pending_o (nmi_pend)
   );

   assign irq_ok     = ~irq_n & ~I_flag;
   assign stack_addr = {STACK_PAGE, SP_in};

   // Vector base for the latched source; BRK shares IRQ's
   always_comb begin
      unique case (src_q)
         SRC_RST: vec_base = RST_VEC;
         SRC_NMI: vec_base = NMI_VEC;
         default: vec_base = IRQ_VEC;
      endcase
   end

   // Next state and bus/register-file strobes
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      pc_d       = pc_q;
      p_d        = p_q;
      vec_d      = vec_q;
      rst_pend_d = rst_pend_q;
      nmi_clr    = 1'b0;
      mem_addr   = 16'h0000;
      mem_wdata  = 8'h00;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      dec_SP     = 1'b0;
      set_I      = 1'b0;
      pc_load    = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (rst_pend_q) begin
               rst_pend_d = 1'b0;
               src_d      = SRC_RST;
               state_d    = ST_VEC_LO;
            end else if (at_boundary &&
                         (nmi_pend || brk_req || irq_ok)) begin
               pc_d    = PC_in;
               p_d     = P_in;
               state_d = ST_PUSH_PCH;
               if (nmi_pend) begin
                  src_d   = SRC_NMI;
                  nmi_clr = 1'b1;
               end else if (brk_req) begin
                  src_d = SRC_BRK;
               end else begin
                  src_d = SRC_IRQ;
               end
            end
         end

         ST_PUSH_PCH: begin
            mem_addr  = stack_addr;
            mem_wdata = pc_q[15:8];
            mem_we    = 1'b1;
            if (mem_ready) begin
               dec_SP  = 1'b1;
               state_d = ST_PUSH_PCL;
            end
         end

         ST_PUSH_PCL: begin
            mem_addr  = stack_addr;
            mem_wdata = pc_q[7:0];
            mem_we    = 1'b1;
            if (mem_ready) begin
               dec_SP  = 1'b1;
               state_d = ST_PUSH_P;
            end
         end

         ST_PUSH_P: begin
            mem_addr  = stack_addr;
            mem_wdata = push_status(p_q, src_q == SRC_BRK);
            mem_we    = 1'b1;
            if (mem_ready) begin
               dec_SP  = 1'b1;
               set_I   = 1'b1;
               state_d = ST_VEC_LO;
            end
         end

         ST_VEC_LO: begin
            mem_addr = vec_base;
            mem_re   = 1'b1;
            if (mem_ready) begin
               vec_d[7:0] = mem_rdata;
               set_I      = (src_q == SRC_RST);
               state_d    = ST_VEC_HI;
            end
         end

         ST_VEC_HI: begin
            mem_addr = vec_base + 16'd1;
            mem_re   = 1'b1;
            if (mem_ready) begin
               vec_d[15:8] = mem_rdata;
               state_d     = ST_LOAD_PC;
            end
         end

         ST_LOAD_PC: begin
            pc_load = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state and captured context
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         src_q      <= SRC_RST;
         pc_q       <= 16'h0000;
         p_q        <= 8'h00;
         vec_q      <= 16'h0000;
         rst_pend_q <= FETCH_RESET_VECTOR;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         pc_q       <= pc_d;
         p_q        <= p_d;
         vec_q      <= vec_d;
         rst_pend_q <= rst_pend_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign int_src  = src_q;
   assign pc_value = vec_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized scoreboard bench for interrupt_sequencer:
// a high-level model predicts every bus access and PC load.
module tb_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        nmi_n = 1'b1;
   logic        irq_n = 1'b1;
   logic        brk_req = 1'b0;
   logic        at_boundary = 1'b0;
   logic        I_flag = 1'b0;
   logic [15:0] PC_in = 16'h0000;
   logic [7:0]  SP_in = 8'hFF;
   logic [7:0]  P_in = 8'h00;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic        dec_SP;
   logic        set_I;
   logic        pc_load;
   logic [15:0] pc_value;
   logic        busy;
   logic        done;
   logic [1:0]  int_src;

   always #5 clk = ~clk;

   interrupt_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .nmi_n       (nmi_n),
      .irq_n       (irq_n),
      .brk_req     (brk_req),
      .at_boundary (at_boundary),
      .I_flag      (I_flag),
      .PC_in       (PC_in),
      .SP_in       (SP_in),
      .P_in        (P_in),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .dec_SP      (dec_SP),
      .set_I       (set_I),
      .pc_load     (pc_load),
      .pc_value    (pc_value),
      .busy        (busy),
      .done        (done),
      .int_src     (int_src)
   );

   typedef struct {
      int          kind;   // 0 write, 1 read, 2 pc load
      logic [15:0] addr;   // bus address, or new PC for kind 2
      logic [7:0]  data;
      logic [1:0]  src;
      int          ndec;
      int          nseti;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   int          passes = 0;
   int          total = 0;
   logic [7:0]  vmem [0:5];
   logic [7:0]  m_sp = 8'hFF;
   logic        m_nmi = 1'b0;
   logic [15:0] last_base = 16'h0000;
   int          ready_mode = 1;
   int          wait_cnt = 0;

   function automatic void chk(input string nm,
                               input logic [31:0] act,
                               input logic [31:0] req);
      total++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, req);
   endfunction

   function automatic logic [7:0] rd(input logic [15:0] a);
      int idx;
      idx = int'(a) - 32'hFFFA;
      if (idx >= 0 && idx < 6) return vmem[idx];
      return 8'h00;
   endfunction

   // Register file stand-in: SP follows the decrement pulses
   always @(posedge clk) if (dec_SP) SP_in <= SP_in - 8'd1;

   // Memory: ready pattern per mode, read data from vector table
   always @(posedge clk) begin
      #1;
      if (ready_mode == 1) mem_ready = 1'b1;
      else if (ready_mode == 2) begin
         if ((mem_we || mem_re) && wait_cnt < 3) begin
            mem_ready = 1'b0;
            wait_cnt++;
         end else begin
            mem_ready = 1'b1;
            wait_cnt = 0;
         end
      end else mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = rd(mem_addr);
   end

   // Monitor: compares every completed access and PC load
   int          cyc = 0;
   int          anchor = 0;
   logic        rst_seen = 1'b0;
   int          dec_cnt = 0;
   int          seti_cnt = 0;
   logic        stall_prev = 1'b0;
   logic [15:0] prev_addr;
   logic [7:0]  prev_wdata;
   logic [1:0]  prev_str;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!reset_n) begin
         rst_seen   = 1'b0;
         dec_cnt    = 0;
         seti_cnt   = 0;
         stall_prev = 1'b0;
      end else begin
         if (!rst_seen) begin
            anchor   = cyc;
            rst_seen = 1'b1;
         end
         if (at_boundary && !busy) anchor = cyc;
         if (stall_prev) begin
            chk("hold_addr", 32'(mem_addr), 32'(prev_addr));
            chk("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
            chk("hold_strobe", 32'({mem_we, mem_re}),
                32'(prev_str));
         end
         stall_prev = (mem_we || mem_re) && !mem_ready;
         prev_addr  = mem_addr;
         prev_wdata = mem_wdata;
         prev_str   = {mem_we, mem_re};
         if (dec_SP) dec_cnt++;
         if (set_I) seti_cnt++;
         if (done || pc_load)
            chk("done_with_load", 32'(done), 32'(pc_load));
         if ((mem_we || mem_re) && mem_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_access: addr %0h we %0b",
                        mem_addr, mem_we);
            end else begin
               e = exp_q.pop_front();
               chk("access_kind", mem_we ? 32'd0 : 32'd1,
                   32'(e.kind));
               chk("access_addr", 32'(mem_addr), 32'(e.addr));
               if (mem_we)
                  chk("write_data", 32'(mem_wdata), 32'(e.data));
            end
         end
         if (pc_load) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_load: pc %0h", pc_value);
            end else begin
               e = exp_q.pop_front();
               chk("load_kind", 32'd2, 32'(e.kind));
               chk("pc_value", 32'(pc_value), 32'(e.addr));
               chk("int_src", 32'(int_src), 32'(e.src));
               chk("dec_SP_count", 32'(dec_cnt), 32'(e.ndec));
               chk("set_I_count", 32'(seti_cnt), 32'(e.nseti));
               if (e.lat >= 0)
                  chk("latency", 32'(cyc - anchor), 32'(e.lat));
            end
            dec_cnt  = 0;
            seti_cnt = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 400) begin
         step();
         n++;
      end
      if (busy) begin
         total++;
         $display("FAIL idle_timeout: busy still %0b", busy);
      end
   endtask

   // Reference model: full entry sequence for one source
   task automatic push_seq(input logic [1:0] src,
                           input logic [15:0] pc,
                           input logic [7:0] p,
                           input int lat);
      exp_t        e;
      logic [7:0]  ps;
      logic [15:0] base;
      ps    = p | 8'h20;
      ps[4] = (src == 2'd2);
      e.src = src;
      e.lat = -1;
      e.ndec = 0;
      e.nseti = 0;
      e.data = 8'h00;
      if (src != 2'd0) begin
         e.kind = 0;
         e.addr = {8'h01, m_sp};
         e.data = pc[15:8];
         exp_q.push_back(e);
         e.addr = {8'h01, m_sp - 8'd1};
         e.data = pc[7:0];
         exp_q.push_back(e);
         e.addr = {8'h01, m_sp - 8'd2};
         e.data = ps;
         exp_q.push_back(e);
         m_sp = m_sp - 8'd3;
      end
      base = (src == 2'd0) ? 16'hFFFC :
             (src == 2'd1) ? 16'hFFFA : 16'hFFFE;
      last_base = base;
      e.kind = 1;
      e.data = 8'h00;
      e.addr = base;
      exp_q.push_back(e);
      e.addr = base + 16'd1;
      exp_q.push_back(e);
      e.kind  = 2;
      e.addr  = {rd(base + 16'd1), rd(base)};
      e.ndec  = (src == 2'd0) ? 0 : 3;
      e.nseti = 1;
      e.lat   = lat;
      exp_q.push_back(e);
   endtask

   task automatic nmi_edge();
      nmi_n = 1'b0;
      step();
      nmi_n = 1'b1;
      step();
      m_nmi = 1'b1;
   endtask

   task automatic issue(input logic brk, input logic irqn,
                        input logic iflg, input logic ne,
                        input logic [15:0] pc,
                        input logic [7:0] p, input int lat);
      logic       take;
      logic [1:0] src;
      wait_idle();
      if (ne) nmi_edge();
      PC_in   = pc;
      P_in    = p;
      I_flag  = iflg;
      irq_n   = irqn;
      brk_req = brk;
      take    = 1'b1;
      src     = 2'd0;
      if (m_nmi) begin
         src   = 2'd1;
         m_nmi = 1'b0;
      end else if (brk) src = 2'd2;
      else if (!irqn && !iflg) src = 2'd3;
      else take = 1'b0;
      if (take) push_seq(src, pc, p, lat);
      at_boundary = 1'b1;
      step();
      at_boundary = 1'b0;
      brk_req     = 1'b0;
      irq_n       = 1'b1;
      if (take) chk("busy_after_accept", 32'(busy), 32'd1);
      else begin
         for (int k = 0; k < 3; k++) begin
            chk("no_sequence_busy", 32'(busy), 32'd0);
            step();
         end
      end
   endtask

   initial begin
      logic found;
      for (int i = 0; i < 6; i++) vmem[i] = 8'($urandom);
      vmem[2] = 8'h00;
      vmem[3] = 8'hFF;
      ready_mode = 1;
      repeat (3) step();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_addr", 32'(mem_addr), 32'd0);
      chk("reset_int_src", 32'(int_src), 32'd0);
      push_seq(2'd0, 16'h0000, 8'h00, 3);
      reset_n = 1'b1;
      step();
      wait_idle();

      ready_mode = 1;
      issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h20, 6);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 8'h24, -1);
      ready_mode = 2;
      issue(1'b1, 1'b1, 1'b0, 1'b0, 16'hC0DE, 8'hA1, -1);
      ready_mode = 0;
      issue(1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 8'h03, -1);
      step();
      nmi_edge();
      issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h9000, 8'h80, -1);

      for (int i = 0; i < 40; i++) begin
         wait_idle();
         ready_mode = $urandom_range(0, 2);
         issue(1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0),
               16'($urandom), 8'($urandom),
               (ready_mode == 1) ? 6 : -1);
         if (busy && $urandom_range(0, 3) == 0) nmi_edge();
      end
      wait_idle();

      ready_mode = 0;
      issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 8'h00, -1);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (mem_re && mem_addr == last_base + 16'd1) found = 1'b1;
      end
      if (!found) begin
         total++;
         $display("FAIL vec_hi_timeout: never reached %0h",
                  last_base + 16'd1);
      end
      #1 reset_n = 1'b0;
      #1;
      chk("abort_addr", 32'(mem_addr), 32'd0);
      chk("abort_wdata", 32'(mem_wdata), 32'd0);
      chk("abort_strobes", 32'({mem_we, mem_re, dec_SP, set_I}),
          32'd0);
      chk("abort_load", 32'({pc_load, done, busy}), 32'd0);
      chk("abort_pc_value", 32'(pc_value), 32'd0);
      chk("abort_int_src", 32'(int_src), 32'd0);
      exp_q.delete();
      m_nmi = 1'b0;
      step();
      step();
      vmem[2] = 8'($urandom);
      vmem[3] = 8'($urandom);
      ready_mode = 1;
      push_seq(2'd0, 16'h0000, 8'h00, 3);
      reset_n = 1'b1;
      step();
      wait_idle();
      issue(1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 8'h41, 6);
      wait_idle();
      repeat (3) step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
